// File: rtl/nas_vid_rx_pkg.sv
// Shared types and default timing for the 1-bit composite video receiver.
// Latency: none (declarations only).
// Backpressure: not applicable.
// Contents: line FSM state enum, default timing constants, counter widths,
//           and the scanline advance helper used on each accepted hsync.
package nas_vid_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_H = 2'd1,
    ST_PORCH  = 2'd2,
    ST_ACTIVE = 2'd3
  } line_state_t;

  // Default timing in clk cycles (16 MHz clock, 2 clk per pixel).
  localparam int unsigned SYNC_MIN_DEF  = 16;
  localparam int unsigned HSYNC_MAX_DEF = 96;
  localparam int unsigned H_OFFSET_DEF  = 160;
  localparam int unsigned CHARS_DEF     = 48;

  localparam int          WCNT_W   = 12;
  localparam logic [11:0] WCNT_MAX = 12'hFFF;
  localparam int          PORCH_W  = 12;
  localparam int          LINE_W   = 9;
  localparam logic [8:0]  LINE_MAX = 9'd511;

  // Scanline index after an accepted hsync: the first hsync following a
  // vsync yields line 0, later ones count up and stick at LINE_MAX.
  function automatic logic [8:0] line_next(input logic armed, input logic [8:0] line);
    if (armed) begin
      return 9'd0;
    end
    if (line == LINE_MAX) begin
      return LINE_MAX;
    end
    return line + 9'd1;
  endfunction

endpackage

// File: rtl/nas_vid_rx_sync.sv
// Input synchronisers, sync edge detection and sync pulse width classifier.
// Latency: 2 clk synchroniser delay; classification pulses in the rise cycle.
// Backpressure: none; every output is a single-cycle strobe or level.
// Ports: clk, rst (sync, active-high); vid_sync/vid_data raw async inputs;
//        hsync_ok/vsync_ok/glitch pulse on sync rise, sync_fall on sync fall,
//        data_s is the synchronised pixel video.
module nas_vid_rx_sync
  import nas_vid_rx_pkg::*;
#(
  parameter int unsigned SYNC_MIN  = SYNC_MIN_DEF,
  parameter int unsigned HSYNC_MAX = HSYNC_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic vid_sync,
  input  logic vid_data,
  output logic hsync_ok,
  output logic vsync_ok,
  output logic glitch,
  output logic sync_fall,
  output logic data_s
);

  logic              sync_m;
  logic              sync_s;
  logic              sync_d;
  logic              data_m;
  logic              sync_rise;
  logic [WCNT_W-1:0] wcnt;

  // Sync idles high, so its flops reset to 1 to avoid a false edge.
  // The width counter restarts at 1 on the first low cycle, so at the rising
  // edge it holds the exact number of cycles the synchronised sync was low.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_m <= 1'b1;
      sync_s <= 1'b1;
      sync_d <= 1'b1;
      data_m <= 1'b0;
      data_s <= 1'b0;
      wcnt   <= '0;
    end else begin
      sync_m <= vid_sync;
      sync_s <= sync_m;
      sync_d <= sync_s;
      data_m <= vid_data;
      data_s <= data_m;
      if (sync_fall) begin
        wcnt <= 12'd1;
      end else if (!sync_s && (wcnt != WCNT_MAX)) begin
        wcnt <= wcnt + 12'd1;
      end
    end
  end

  assign sync_fall = sync_d & ~sync_s;
  assign sync_rise = ~sync_d & sync_s;

  assign glitch   = sync_rise && (wcnt <  12'(SYNC_MIN));
  assign hsync_ok = sync_rise && (wcnt >= 12'(SYNC_MIN)) && (wcnt <= 12'(HSYNC_MAX));
  assign vsync_ok = sync_rise && (wcnt >  12'(HSYNC_MAX));

endmodule

// File: rtl/nas_vid_rx.sv
// Composite 1-bit video receiver: locks to vsync, times each scanline from
// hsync and captures CHARS bytes of 8 pixels per line.
// Latency: pix_valid one cycle after the 8th pixel sample (2 clk sync delay).
// Backpressure: none; pix_valid is a single-cycle strobe the sink must take.
// Ports: clk, rst (sync, active-high); vid_sync (active-low), vid_data raw;
//        pix_valid/pix_byte/pix_col/pix_line captured byte, frame_start on
//        vsync, locked after first vsync, sync_err sticky until rst.
module nas_vid_rx
  import nas_vid_rx_pkg::*;
#(
  parameter int unsigned SYNC_MIN  = SYNC_MIN_DEF,
  parameter int unsigned HSYNC_MAX = HSYNC_MAX_DEF,
  parameter int unsigned H_OFFSET  = H_OFFSET_DEF,
  parameter int unsigned CHARS     = CHARS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vid_sync,
  input  logic       vid_data,
  output logic       pix_valid,
  output logic [7:0] pix_byte,
  output logic [5:0] pix_col,
  output logic [8:0] pix_line,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  logic               hsync_ok;
  logic               vsync_ok;
  logic               glitch;
  logic               sync_fall;
  logic               data_s;

  line_state_t        state;
  logic [PORCH_W-1:0] porch_cnt;
  logic               phase;
  logic [2:0]         bit_cnt;
  logic [6:0]         shreg;
  logic [5:0]         col_cnt;
  logic               armed;

  nas_vid_rx_sync #(
    .SYNC_MIN  (SYNC_MIN),
    .HSYNC_MAX (HSYNC_MAX)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .vid_sync  (vid_sync),
    .vid_data  (vid_data),
    .hsync_ok  (hsync_ok),
    .vsync_ok  (vsync_ok),
    .glitch    (glitch),
    .sync_fall (sync_fall),
    .data_s    (data_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      porch_cnt   <= '0;
      phase       <= 1'b0;
      bit_cnt     <= '0;
      shreg       <= '0;
      col_cnt     <= '0;
      armed       <= 1'b0;
      pix_valid   <= 1'b0;
      pix_byte    <= '0;
      pix_col     <= '0;
      pix_line    <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;

      if (glitch) begin
        sync_err <= 1'b1;
      end

      // Vsync wins over anything a line was doing. pix_line keeps its value
      // until the next hsync, which then starts the frame at line 0.
      if (vsync_ok) begin
        frame_start <= 1'b1;
        locked      <= 1'b1;
        armed       <= 1'b1;
        state       <= ST_WAIT_H;
      end else if (sync_fall && ((state == ST_PORCH) || (state == ST_ACTIVE))) begin
        // A new sync pulse starting mid-line abandons the line; any partial
        // byte in shreg is simply never emitted.
        if (state == ST_ACTIVE) begin
          sync_err <= 1'b1;
        end
        state <= ST_WAIT_H;
      end else if (hsync_ok && (state != ST_IDLE)) begin
        pix_line  <= line_next(armed, pix_line);
        armed     <= 1'b0;
        porch_cnt <= 12'(H_OFFSET);
        state     <= ST_PORCH;
      end else begin
        case (state)
          ST_IDLE, ST_WAIT_H: begin
          end
          ST_PORCH: begin
            if (porch_cnt == '0) begin
              state   <= ST_ACTIVE;
              phase   <= 1'b0;
              bit_cnt <= '0;
              col_cnt <= '0;
              shreg   <= '0;
            end else begin
              porch_cnt <= porch_cnt - 12'd1;
            end
          end
          ST_ACTIVE: begin
            // Each pixel spans two cycles; sampling on phase 1 lands on the
            // second half of the pixel, clear of the transition.
            phase <= ~phase;
            if (phase) begin
              shreg   <= {shreg[5:0], data_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                pix_valid <= 1'b1;
                pix_byte  <= {shreg, data_s};
                pix_col   <= col_cnt;
                if (col_cnt == 6'(CHARS - 1)) begin
                  state <= ST_WAIT_H;
                end else begin
                  col_cnt <= col_cnt + 6'd1;
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nas_vid_rx.sv
module tb_nas_vid_rx;

  localparam int SYNC_MIN  = 16;
  localparam int HSYNC_MAX = 96;
  localparam int H_OFFSET  = 160;
  localparam int CHARS     = 48;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vid_sync = 1'b1;
  logic       vid_data = 1'b0;
  logic       pix_valid;
  logic [7:0] pix_byte;
  logic [5:0] pix_col;
  logic [8:0] pix_line;
  logic       frame_start;
  logic       locked;
  logic       sync_err;

  nas_vid_rx #(
    .SYNC_MIN  (SYNC_MIN),
    .HSYNC_MAX (HSYNC_MAX),
    .H_OFFSET  (H_OFFSET),
    .CHARS     (CHARS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .vid_sync    (vid_sync),
    .vid_data    (vid_data),
    .pix_valid   (pix_valid),
    .pix_byte    (pix_byte),
    .pix_col     (pix_col),
    .pix_line    (pix_line),
    .frame_start (frame_start),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int fs_seen = 0;
  logic [22:0] obs_q[$];
  logic [22:0] exp_q[$];

  // Reference model state: frame/line bookkeeping from the pulse rules.
  int         m_line = 0;
  int         m_fs = 0;
  bit         m_locked = 0;
  bit         m_armed = 0;
  bit         m_err = 0;
  bit         m_cap = 0;
  logic [7:0] last_b = 8'd0;

  always @(negedge clk) begin
    if (pix_valid) obs_q.push_back({pix_line, pix_col, pix_byte});
    if (frame_start) fs_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    m_line = 0;
    m_locked = 0;
    m_armed = 0;
    m_err = 0;
    m_cap = 0;
  endtask

  task automatic model_pulse(input int w);
    if (w < SYNC_MIN) begin
      m_err = 1;
      m_cap = 0;
    end else if (w <= HSYNC_MAX) begin
      m_cap = m_locked;
      if (m_locked) begin
        if (m_armed) m_line = 0;
        else if (m_line < 511) m_line = m_line + 1;
        m_armed = 0;
      end
    end else begin
      m_fs++;
      m_locked = 1;
      m_armed = 1;
      m_cap = 0;
    end
  endtask

  // Sync low for exactly w clk cycles, then back high.
  task automatic pulse(input int w);
    vid_sync = 1'b0;
    repeat (w) tick();
    vid_sync = 1'b1;
    model_pulse(w);
  endtask

  // Pixels start H_OFFSET+2 cycles after the sync rise, 2 cycles each.
  task automatic send_line(input int nfull, input int npart, input int pat);
    logic [7:0] b;
    tick();
    repeat (H_OFFSET + 1) tick();
    for (int j = 0; j < nfull; j++) begin
      b = (pat < 0) ? 8'($urandom) : 8'(pat);
      if (m_cap) begin
        exp_q.push_back({9'(m_line), 6'(j), b});
        last_b = b;
      end
      for (int k = 7; k >= 0; k--) begin
        vid_data = b[k];
        tick();
        tick();
      end
    end
    for (int k = 0; k < npart; k++) begin
      vid_data = 1'($urandom);
      tick();
      tick();
    end
    vid_data = 1'b0;
  endtask

  task automatic check_strobes(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk(tag, {9'd0, obs_q[i]}, {9'd0, exp_q[i]});
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_byte"}, pix_byte, 0);
    chk({tag, "_col"}, pix_col, 0);
    chk({tag, "_line"}, pix_line, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err"}, sync_err, 0);
  endtask

  task automatic full_line(input string tag, input int w, input int pat);
    pulse(w);
    send_line(CHARS, 0, pat);
    idle(8);
    check_strobes(tag);
    chk({tag, "_line"}, pix_line, m_line);
    if (m_cap) begin
      chk({tag, "_hold_byte"}, pix_byte, last_b);
      chk({tag, "_hold_col"}, pix_col, CHARS - 1);
    end
  endtask

  initial begin
    int w;
    // Reset state.
    rst = 1'b1;
    idle(3);
    check_all_zero("reset");
    rst = 1'b0;
    idle(5);

    // Hsyncs and pixel data before any vsync are ignored.
    full_line("novs", 50, -1);
    pulse(20);
    idle(10);
    pulse(HSYNC_MAX);
    idle(10);
    check_strobes("novs_tail");
    chk("novs_locked", locked, 0);
    chk("novs_fs", fs_seen, 0);
    chk("novs_err", sync_err, 0);

    // Long vsync then a 0xA5 line.
    pulse(4000);
    idle(20);
    chk("vs_fs", fs_seen, m_fs);
    chk("vs_locked", locked, 1);
    full_line("a5", 75, 8'hA5);
    chk("a5_one_fs", fs_seen, 1);

    // Random lines, including hsync widths at both classifier limits.
    full_line("w16", SYNC_MIN, -1);
    full_line("w96", HSYNC_MAX, -1);
    for (int i = 0; i < 2; i++) begin
      w = $urandom_range(SYNC_MIN, HSYNC_MAX);
      full_line("wrnd", w, -1);
    end
    chk("lines_err", sync_err, 0);

    // Abort after 20 bytes by starting the next hsync mid-line.
    pulse(40);
    send_line(20, 3, -1);
    m_err = 1;
    full_line("abort", 40, -1);
    chk("abort_err", sync_err, m_err);

    // Reset held 3 cycles in the middle of an active line.
    pulse(50);
    send_line(10, 2, -1);
    rst = 1'b1;
    idle(3);
    check_all_zero("midrst");
    rst = 1'b0;
    model_reset();
    check_strobes("midrst_pre");
    full_line("postrst", 50, -1);
    chk("postrst_locked", locked, 0);

    // Relock, two lines, then glitches leave the line count alone.
    pulse(3000);
    idle(20);
    chk("relock_fs", fs_seen, m_fs);
    chk("relock_locked", locked, 1);
    full_line("rl0", 30, -1);
    full_line("rl1", 30, -1);
    chk("pre_glitch_err", sync_err, 0);
    pulse(8);
    idle(10);
    chk("glitch8_err", sync_err, m_err);
    chk("glitch8_line", pix_line, m_line);
    pulse(SYNC_MIN - 1);
    idle(10);
    chk("glitch15_line", pix_line, m_line);
    check_strobes("glitch");

    // Shortest vsync, then the next line restarts at 0.
    pulse(HSYNC_MAX + 1);
    idle(20);
    chk("vs97_fs", fs_seen, m_fs);
    full_line("vs97", $urandom_range(SYNC_MIN, HSYNC_MAX), -1);

    // 600 fast hsyncs saturate the line counter.
    for (int i = 0; i < 600; i++) begin
      pulse($urandom_range(SYNC_MIN, 40));
      idle(10);
    end
    chk("sat_line", pix_line, m_line);
    chk("sat_511", pix_line, 511);
    check_strobes("sat");
    pulse($urandom_range(HSYNC_MAX + 1, 300));
    idle(20);
    full_line("after_sat", $urandom_range(SYNC_MIN, HSYNC_MAX), -1);
    chk("final_fs", fs_seen, m_fs);
    chk("final_err", sync_err, m_err);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/nas_vid_rx.md
NAS_VID_RX -- requirements
Module: nas_vid_rx

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  SYNC_MIN 16: shortest accepted sync pulse, clk cycles
  HSYNC_MAX 96: longest pulse classed as hsync; longer is vsync
  H_OFFSET 160: clk cycles from hsync end to first pixel sample window
  CHARS 48: bytes captured per line
REQ-002 Ports (name, direction, width, meaning), one per line; one clock; reset is synchronous and active-high:
  clk  in  1  16MHz system clock; every pixel spans 2 clk cycles
  rst  in  1  synchronous active-high reset
  vid_sync  in  1  composite sync, active-low, asynchronous to clk
  vid_data  in  1  pixel video, 1 = lit, asynchronous to clk
  pix_valid  out  1  one-cycle strobe, pix_byte/pix_col/pix_line valid
  pix_byte  out  8  8 captured pixels; bit 7 = first pixel on screen
  pix_col  out  6  byte column, 0..CHARS-1
  pix_line  out  9  scanline index since last vsync, saturating at 511
  frame_start  out  1  one-cycle pulse on vsync acceptance
  locked  out  1  1 after first accepted vsync
  sync_err  out  1  sticky error flag

Function
REQ-003 vid_sync and vid_data SHALL each pass a 2-flop synchroniser; all timing below refers to the synchronised signals (2-cycle input latency).
REQ-004 A 12-bit saturating width counter SHALL count cycles while sync is low and clear on sync falling edge.
REQ-005 On sync rising edge with width w: w<SYNC_MIN is a glitch (ignored, sync_err set); SYNC_MIN<=w<=HSYNC_MAX is hsync; w>HSYNC_MAX is vsync.
REQ-006 Line FSM states: IDLE, WAIT_H, PORCH, ACTIVE.
REQ-007 IDLE: hsyncs ignored; vsync -> WAIT_H.
REQ-008 Every accepted vsync SHALL pulse frame_start in the cycle after the rising edge, set locked=1, arm pix_line so the next hsync yields line 0, enter WAIT_H.
REQ-009 Hsync when locked: pix_line advances (first after vsync = 0, saturating 511), porch counter loads H_OFFSET, enter PORCH.
REQ-010 PORCH: decrement each cycle; at 0 enter ACTIVE with pixel phase 0, bit count 0, pix_col 0.
REQ-011 ACTIVE: phase toggles each cycle; vid_data sampled at phase 1 and shifted in MSB-first.
REQ-012 After the 8th sample, pix_valid SHALL assert for exactly one cycle in the next cycle with pix_byte, pix_col, pix_line stable; pix_col then increments.
REQ-013 After byte CHARS-1 the FSM SHALL return to WAIT_H; further pixels ignored until next hsync.
REQ-014 Sync falling edge in PORCH or ACTIVE SHALL abort the line, discard any partial byte, set sync_err if ACTIVE, and enter WAIT_H; the pulse is then classified normally.
REQ-015 Vsync in any state overrides line activity (REQ-008).
REQ-016 pix_byte, pix_col, pix_line SHALL hold their last values between strobes.
REQ-017 sync_err clears only on rst.

Reset
REQ-018 rst SHALL force state IDLE, all outputs 0, counters 0, synchroniser flops 1 for sync and 0 for data, in the cycle it is sampled, including mid-line.
REQ-019 After rst deassertion no pix_valid SHALL occur before an accepted vsync.

Structure
REQ-020 Package nas_vid_rx_pkg SHALL hold the FSM state enum and default timing constants.
REQ-021 Sub-module nas_vid_rx_sync SHALL contain the synchronisers, sync edge detect and width counter/classifier, outputting hsync_ok, vsync_ok, glitch, sync_fall, data_s.

Verification
REQ-022 rst held 3 cycles mid-ACTIVE -> next cycle all outputs 0, locked 0; following hsync produces no pix_valid.
REQ-023 vsync low 4000 cycles, hsync low 75 cycles, then after H_OFFSET+2 cycles pixels of 0xA5 -> one frame_start, 48 pix_valid strobes, pix_byte 0xA5, pix_col 0..47, pix_line 0.
REQ-024 Sync low 8 cycles while locked -> sync_err=1, pix_line unchanged, no strobe.
REQ-025 Hsyncs before any vsync -> locked 0, no pix_valid, no frame_start.
REQ-026 Sync falls after 20 bytes of a line -> no further strobe that line, sync_err=1; next hsync gives pix_line +1, pix_col restarts at 0.
REQ-027 600 hsyncs after one vsync -> pix_line reaches 511 and holds; next vsync then hsync gives pix_line 0.
